// File: rtl/overture_pkg.sv
// Shared definitions for the Overture decode stage.
//   - class indices (bit positions in the one-hot class vector)
//   - ALU operation and condition-code encodings
//   - dec_rec_t: decoded-instruction record. Fields are sized to the widest
//     supported configuration (OPC_W <= 32, FLD_W <= 16). Producers zero-extend
//     into these fields and consumers slice back to the configured widths.
package overture_pkg;

    localparam int unsigned N_CLS         = 4;
    localparam int unsigned DEC_IMM_MAX_W = 32;
    localparam int unsigned DEC_FLD_MAX_W = 16;

    localparam int unsigned CLS_IMM  = 0;
    localparam int unsigned CLS_CALC = 1;
    localparam int unsigned CLS_COPY = 2;
    localparam int unsigned CLS_COND = 3;

    typedef enum logic [2:0] {
        ALU_OR   = 3'd0,
        ALU_NAND = 3'd1,
        ALU_NOR  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_ADD  = 3'd4,
        ALU_SUB  = 3'd5
    } alu_op_e;

    typedef enum logic [2:0] {
        COND_NEVER  = 3'd0,
        COND_EQ0    = 3'd1,
        COND_LT0    = 3'd2,
        COND_LE0    = 3'd3,
        COND_ALWAYS = 3'd4,
        COND_NE0    = 3'd5,
        COND_GE0    = 3'd6,
        COND_GT0    = 3'd7
    } cond_e;

    typedef struct packed {
        logic [N_CLS-1:0]         cls;
        logic [DEC_IMM_MAX_W-1:0] imm;
        logic [DEC_FLD_MAX_W-1:0] src;
        logic [DEC_FLD_MAX_W-1:0] dst;
        logic [DEC_FLD_MAX_W-1:0] alu_op;
        logic [DEC_FLD_MAX_W-1:0] cond;
        logic                     illegal;
    } dec_rec_t;

    // Two-bit class code to one-hot {COND,COPY,CALC,IMM}.
    function automatic logic [N_CLS-1:0] cls_onehot(input logic [1:0] code);
        return N_CLS'(1) << code;
    endfunction

endpackage

// File: rtl/overture_dec_fields.sv
// Purely combinational opcode -> decoded record.
// Every field is extracted from the same opcode bits regardless of class;
// only the illegal flag is class-qualified (CALC with an undefined ALU op).
// Ports:
//   i_opcode  in   OPC_W      raw opcode
//   o_rec     out  dec_rec_t  decoded record (zero-extended fields)
module overture_dec_fields
    import overture_pkg::*;
#(
    parameter int unsigned OPC_W   = 8,
    parameter int unsigned FLD_W   = 3,
    parameter int unsigned ALU_OPS = 6
) (
    input  logic [OPC_W-1:0] i_opcode,
    output dec_rec_t         o_rec
);

    logic [N_CLS-1:0] w_cls;
    logic [FLD_W-1:0] w_low_fld;

    assign w_cls     = cls_onehot(i_opcode[OPC_W-1 -: 2]);
    assign w_low_fld = i_opcode[FLD_W-1:0];

    always_comb begin
        o_rec         = '0;
        o_rec.cls     = w_cls;
        o_rec.imm     = DEC_IMM_MAX_W'(i_opcode[OPC_W-3:0]);
        o_rec.src     = DEC_FLD_MAX_W'(i_opcode[2*FLD_W-1:FLD_W]);
        o_rec.dst     = DEC_FLD_MAX_W'(w_low_fld);
        o_rec.alu_op  = DEC_FLD_MAX_W'(w_low_fld);
        o_rec.cond    = DEC_FLD_MAX_W'(w_low_fld);
        o_rec.illegal = w_cls[CLS_CALC] && (32'(w_low_fld) >= ALU_OPS);
    end

endmodule

// File: rtl/overture_decode_stage.sv
// Registered Overture decode stage between fetch and execute.
// A 2-entry buffer of decoded records sits behind a valid/ready handshake;
// in_ready depends only on the fill level and flush, never on out_ready.
// Optional feature macro: OVERTURE_DEC_PERF_EN adds four saturating per-class
// retire counters on the perf_cnt port.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   flush          discard all buffered entries
//   in_valid/in_ready/in_opcode        upstream handshake + raw opcode
//   out_valid/out_ready                downstream handshake
//   out_class      one-hot {COND,COPY,CALC,IMM}
//   out_imm/out_src/out_dst/out_alu_op/out_cond/out_illegal  head fields
//   perf_cnt       per-class retire counts (OVERTURE_DEC_PERF_EN only)
module overture_decode_stage
    import overture_pkg::*;
#(
    parameter int unsigned OPC_W   = 8,
    parameter int unsigned FLD_W   = 3,
    parameter int unsigned ALU_OPS = 6,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPC_W-1:0]   in_opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_class,
    output logic [OPC_W-3:0]   out_imm,
    output logic [FLD_W-1:0]   out_src,
    output logic [FLD_W-1:0]   out_dst,
    output logic [FLD_W-1:0]   out_alu_op,
    output logic [FLD_W-1:0]   out_cond,
    output logic               out_illegal
`ifdef OVERTURE_DEC_PERF_EN
    ,
    output logic [4*CNT_W-1:0] perf_cnt
`endif
);

    localparam int unsigned IMM_W = OPC_W - 2;

    // Reject configurations the record layout or field map cannot hold.
    if ((OPC_W < 8) || (OPC_W % 2 != 0) || (OPC_W > DEC_IMM_MAX_W) ||
        (2 * FLD_W > OPC_W - 2) || (FLD_W < 1) || (CNT_W < 1)) begin : g_bad_params
        $error("overture_decode_stage: unsupported OPC_W/FLD_W/CNT_W combination");
    end

    logic [1:0] r_count;
    dec_rec_t   r_head;
    dec_rec_t   r_tail;

    logic [1:0] w_count_nxt;
    dec_rec_t   w_head_nxt;
    dec_rec_t   w_tail_nxt;
    dec_rec_t   w_dec;
    logic       w_push;
    logic       w_pop;

    overture_dec_fields #(
        .OPC_W   (OPC_W),
        .FLD_W   (FLD_W),
        .ALU_OPS (ALU_OPS)
    ) u_fields (
        .i_opcode (in_opcode),
        .o_rec    (w_dec)
    );

    assign in_ready  = (r_count != 2'd2) & ~flush;
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Buffer next-state: head is always the oldest entry.
    always_comb begin
        w_count_nxt = r_count;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        if (flush) begin
            w_count_nxt = 2'd0;
        end else begin
            unique case (r_count)
                2'd0: begin
                    if (w_push) begin
                        w_head_nxt  = w_dec;
                        w_count_nxt = 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        w_head_nxt = w_dec;
                    end else if (w_push) begin
                        w_tail_nxt  = w_dec;
                        w_count_nxt = 2'd2;
                    end else if (w_pop) begin
                        w_count_nxt = 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        w_head_nxt  = r_tail;
                        w_count_nxt = 2'd1;
                    end
                end
                default: begin
                    w_count_nxt = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    assign out_class   = r_head.cls;
    assign out_imm     = r_head.imm[IMM_W-1:0];
    assign out_src     = r_head.src[FLD_W-1:0];
    assign out_dst     = r_head.dst[FLD_W-1:0];
    assign out_alu_op  = r_head.alu_op[FLD_W-1:0];
    assign out_cond    = r_head.cond[FLD_W-1:0];
    assign out_illegal = r_head.illegal;

    // Upper record bits are always zero for the configured widths.
    logic w_unused_hi;
    assign w_unused_hi = ^{r_head.imm[DEC_IMM_MAX_W-1:IMM_W],
                           r_head.src[DEC_FLD_MAX_W-1:FLD_W],
                           r_head.dst[DEC_FLD_MAX_W-1:FLD_W],
                           r_head.alu_op[DEC_FLD_MAX_W-1:FLD_W],
                           r_head.cond[DEC_FLD_MAX_W-1:FLD_W]};

`ifdef OVERTURE_DEC_PERF_EN
    logic [N_CLS-1:0][CNT_W-1:0] r_perf;

    // Retire counters: a pop coinciding with flush still counts; flush never clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf <= '0;
        end else begin
            for (int k = 0; k < int'(N_CLS); k++) begin
                if (w_pop && r_head.cls[k] && (r_perf[k] != '1)) begin
                    r_perf[k] <= r_perf[k] + CNT_W'(1);
                end
            end
        end
    end

    assign perf_cnt = r_perf;
`endif

endmodule
